// File: rtl/voice_allocator.sv
// voice_allocator: polyphony controller. A note scanner visits one key per
// cycle, hands newly pressed notes to the lowest free voice and frees voices
// whose note is released. The arrow keys step a shared octave and cycle a
// shared waveform select.
// Optional feature macro: VOICE_STEAL_EN. When defined, a press that finds
// no free voice takes over the oldest voice. When undefined, the press is
// dropped and only the sticky overflow flag records it.
module voice_allocator #(
    parameter int         NUM_VOICES = 4,
    parameter logic [2:0] OCT_RESET  = 3'd4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [15:0]               keyboard_key,
    output logic [NUM_VOICES-1:0]     voice_enable,
    output logic [4*NUM_VOICES-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]     voice_start,
    output logic [2:0]                octave,
    output logic [1:0]                wave,
    output logic                      overflow
);

    logic [3:0]            idx_reg;
    logic [11:0]           held_reg;
    logic [3:0]            arrow_q_reg;
    logic [NUM_VOICES-1:0] enable_reg;
    logic [3:0]            note_reg [NUM_VOICES];
    logic [NUM_VOICES-1:0] start_reg;
    logic [2:0]            octave_reg;
    logic [1:0]            wave_reg;
    logic                  overflow_reg;

    logic                  key_now;
    logic                  key_held;
    logic                  note_rise;
    logic                  note_fall;
    logic                  free_found;
    logic [NUM_VOICES-1:0] free_onehot;
    logic [NUM_VOICES-1:0] alloc_onehot;
    logic [NUM_VOICES-1:0] release_vec;
    logic [3:0]            arrow_rise;

    // Edge detection on the key currently under the scan pointer
    assign key_now   = keyboard_key[idx_reg];
    assign key_held  = held_reg[idx_reg];
    assign note_rise = key_now & ~key_held;
    assign note_fall = ~key_now & key_held;

    // Arrow rising edges: bit 0 Up, 1 Down, 2 Left, 3 Right
    assign arrow_rise = keyboard_key[15:12] & ~arrow_q_reg;

    // Per-voice release match and output packing
    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign release_vec[gi]         = note_fall && enable_reg[gi] && (note_reg[gi] == idx_reg);
            assign voice_note[4*gi +: 4]   = note_reg[gi];
        end
    endgenerate

    // Lowest-index voice that is currently idle
    always_comb begin
        free_found  = 1'b0;
        free_onehot = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!free_found && !enable_reg[v]) begin
                free_onehot[v] = 1'b1;
                free_found     = 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [7:0]            age_reg [NUM_VOICES];
    logic [NUM_VOICES-1:0] steal_onehot;
    logic [7:0]            best_age;
    int                    best_v;

    // Oldest voice, ties resolved toward the lowest index by strict compare
    always_comb begin
        best_age     = age_reg[0];
        best_v       = 0;
        steal_onehot = '0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_reg[v] > best_age) begin
                best_age = age_reg[v];
                best_v   = v;
            end
        end
        steal_onehot[best_v] = 1'b1;
    end

    // Voice chosen for a new press: a free one, else the oldest one
    always_comb begin
        alloc_onehot = '0;
        if (note_rise)
            alloc_onehot = free_found ? free_onehot : steal_onehot;
    end

    // Age counters: restart on (re)assignment, saturate while held, 0 when idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++)
                age_reg[v] <= 8'd0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (alloc_onehot[v] || release_vec[v] || !enable_reg[v])
                    age_reg[v] <= 8'd0;
                else if (age_reg[v] != 8'hFF)
                    age_reg[v] <= age_reg[v] + 8'd1;
            end
        end
    end
`else
    // Voice chosen for a new press: a free one, else nothing (press dropped)
    always_comb begin
        alloc_onehot = '0;
        if (note_rise && free_found)
            alloc_onehot = free_onehot;
    end
`endif

    // Scanner, voice table and overflow flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx_reg      <= 4'd0;
            held_reg     <= 12'd0;
            enable_reg   <= '0;
            start_reg    <= '0;
            overflow_reg <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++)
                note_reg[v] <= 4'd0;
        end else begin
            idx_reg           <= (idx_reg == 4'd11) ? 4'd0 : idx_reg + 4'd1;
            held_reg[idx_reg] <= key_now;
            start_reg         <= alloc_onehot;
            if (note_rise && !free_found)
                overflow_reg <= 1'b1;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (alloc_onehot[v]) begin
                    enable_reg[v] <= 1'b1;
                    note_reg[v]   <= idx_reg;
                end else if (release_vec[v]) begin
                    enable_reg[v] <= 1'b0;
                end
            end
        end
    end

    // Shared octave (saturating) and waveform (wrapping) controls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arrow_q_reg <= 4'd0;
            octave_reg  <= OCT_RESET;
            wave_reg    <= 2'd0;
        end else begin
            arrow_q_reg <= keyboard_key[15:12];
            if (arrow_rise[0] && !arrow_rise[1] && octave_reg != 3'd7)
                octave_reg <= octave_reg + 3'd1;
            else if (arrow_rise[1] && !arrow_rise[0] && octave_reg != 3'd0)
                octave_reg <= octave_reg - 3'd1;
            if (arrow_rise[3] && !arrow_rise[2])
                wave_reg <= wave_reg + 2'd1;
            else if (arrow_rise[2] && !arrow_rise[3])
                wave_reg <= wave_reg - 2'd1;
        end
    end

    assign voice_enable = enable_reg;
    assign voice_start  = start_reg;
    assign octave       = octave_reg;
    assign wave         = wave_reg;
    assign overflow     = overflow_reg;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphony controller between `key_interpreter` and a bank of `wave_creator` voices. It scans the 12 note bits of `keyboard_key` and assigns each newly pressed note to a free voice. When a note is released, it frees that note's voice. The four arrow-key bits step a shared octave and cycle a shared waveform select.

## Interface
Parameters:
- `NUM_VOICES`, 4: number of voice slots, legal range 1–8.
- `OCT_RESET`, 3'd4: octave value loaded at reset.

Ports:
- `clock` in 1: system clock, CLOCK_50 domain.
- `reset` in 1: asynchronous, active-high. Clears all state.
- `keyboard_key` in 16: held-key vector from `key_interpreter`.
  - [11:0] notes C..B.
  - [12] Up, [13] Down, [14] Left, [15] Right.
- `voice_enable` out NUM_VOICES: bit v high while voice v holds a note.
- `voice_note` out 4*NUM_VOICES: note index of voice v in [4v+3:4v], range 0–11.
- `voice_start` out NUM_VOICES: 1-cycle pulse when voice v is (re)assigned.
- `octave` out 3: shared octave, range 0–7.
- `wave` out 2: shared waveform select.
- `overflow` out 1: sticky; set when a press finds no voice. Cleared only by reset.

## Operation
Scan:
- Index `idx` runs 0..11 and wraps 11→0. It advances one step per cycle, unconditionally.
- Register `held[11:0]` is the last sampled key state.
- Each cycle, `k = keyboard_key[idx]` is compared with `held[idx]`. Then `held[idx] <= k`, whatever the allocation outcome.
- Rising edge (k=1, held=0): allocate.
  - Choose the lowest-index voice with enable=0.
  - For that voice: enable<=1, note<=idx, age<=0, voice_start pulse.
  - If no voice is free, apply the overflow policy (see Configuration).
- Falling edge (k=0, held=1): every voice with enable=1 and note==idx gets enable<=0. Its note is retained.
  - If no voice matches (the press was dropped), nothing happens.
- No edge: no action.
- Only one key is processed per cycle, so allocation and release never coincide.

Age:
- Each voice has an 8-bit age counter.
- While enabled, it increments every cycle and saturates at 255.
- It reads 0 while the voice is disabled.

Octave and wave:
- Register `arrow_q[3:0]` samples `keyboard_key[15:12]` every cycle. Rising edge = bit 1 now, 0 in `arrow_q`.
- Up edge: octave+1, saturating at 7.
- Down edge: octave−1, saturating at 0.
- Up and Down edges in the same cycle: octave unchanged.
- Right edge: wave+1, wrapping 3→0.
- Left edge: wave−1, wrapping 0→3.
- Left and Right edges in the same cycle: wave unchanged.
- Changes to octave and wave apply to all voices and do not touch the voice state.

## Timing
- Reset values:
  - voice_enable=0, voice_note=0, voice_start=0, octave=OCT_RESET, wave=0, overflow=0.
  - idx=0, held=0, arrow_q=0, all ages=0.
- Note press/release latency: 1–12 cycles from the `keyboard_key` change to the output update, depending on where `idx` is. The worst case is 12 cycles.
- Outputs are registered. voice_start is high in the same cycle that voice_enable/voice_note first show the new assignment.
- Arrow latency: octave/wave update on the clock edge after the arrow bit first reads 1. That is 1 cycle.
- Any toggle of a key shorter than the gap between two visits of the scan to that key is not seen. This is acceptable, because PS/2 event spacing is far above 12 cycles.
- Reset asserted mid-scan clears everything immediately. Keys that are still held when reset releases are treated as new presses on their first scan.

## Configuration
Macro `VOICE_STEAL_EN`:
- Defined: a press with no free voice steals the enabled voice with the largest age. Ties go to the lowest index.
  - The stolen voice gets note<=idx, age<=0 and a voice_start pulse; enable stays 1.
  - overflow is also set.
- Undefined: the press is dropped. overflow<=1, and no voice changes. The age counters and steal comparator are not built.

## Test plan
- Reset → voice_enable=0, octave=4, wave=0, overflow=0.
- Press key 0 (C), wait 12 cycles → voice 0 enable=1, note=0, one voice_start[0] pulse. Release key 0, wait 12 cycles → voice_enable=0.
- Press keys 0, 4, 7, 9 together, then key 11, with NUM_VOICES=4:
  - Voices 0–3 get notes 0, 4, 7, 9 in scan order.
  - Key 11 without the macro: overflow=1, voices unchanged.
  - Key 11 with the macro: voice 0 (the oldest) gets note 11 and overflow=1.
- Release note 4 while 0, 7, 9 are held, then press 2 → voice 1 gets note 2 and the other voices are unchanged.
- Pulse Up 5 times → octave=7 after the third pulse and stays 7. Pulse Down 9 times → octave=0. Up and Down in the same cycle → octave unchanged.
- Pulse Left once from wave=0 → wave=3. Assert reset while 3 voices are active → all outputs return to reset values on the next sample.
